// File: rtl/timer_chn_pkg.sv
// ============================================================================
// Module   : timer_chn_pkg
// Purpose  : Shared mode/edge-select encodings for the timer capture/compare channel.
// Revision : 1.0
// ============================================================================
`default_nettype none

package timer_chn_pkg;

    localparam logic       CHN_MODE_CMP  = 1'b0;
    localparam logic       CHN_MODE_CAP  = 1'b1;

    localparam logic [1:0] CAP_EDGE_NONE = 2'b00;
    localparam logic [1:0] CAP_EDGE_RISE = 2'b01;
    localparam logic [1:0] CAP_EDGE_FALL = 2'b10;
    localparam logic [1:0] CAP_EDGE_BOTH = 2'b11;

    // True when an observed edge direction is enabled by the selector.
    function automatic logic cap_edge_hit(input logic [1:0] sel,
                                          input logic       rise,
                                          input logic       fall);
        logic rise_en;
        logic fall_en;
        rise_en = (sel == CAP_EDGE_RISE) || (sel == CAP_EDGE_BOTH);
        fall_en = (sel == CAP_EDGE_FALL) || (sel == CAP_EDGE_BOTH);
        return (rise && rise_en) || (fall && fall_en);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cap_in_filter.sv
// ============================================================================
// Module   : cap_in_filter
// Purpose  : Capture pin synchroniser, optional glitch filter, registered edge pulses.
//            Filter present only when TIMER_CAP_FILTER_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cap_in_filter #(
    parameter int FILTER_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap_in,
    input  logic [FILTER_WIDTH-1:0] filter_th,
    output logic                    rise,
    output logic                    fall
);

    logic r_sync1;
    logic r_cap_s;
    logic w_cap_f;
    logic r_cap_f_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_cap_s <= 1'b0;
        end else begin
            r_sync1 <= cap_in;
            r_cap_s <= r_sync1;
        end
    end

`ifdef TIMER_CAP_FILTER_EN
    logic                    r_cap_s_d;
    logic                    r_cap_f;
    logic [FILTER_WIDTH-1:0] r_run;
    logic [FILTER_WIDTH-1:0] w_run;

    // w_run = cycles cap_s has held its present value, minus one.
    always_comb begin
        w_run = r_run;
        if (r_cap_s != r_cap_s_d) begin
            w_run = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_s_d <= 1'b0;
            r_run     <= '0;
            r_cap_f   <= 1'b0;
        end else begin
            r_cap_s_d <= r_cap_s;
            if (w_run != {FILTER_WIDTH{1'b1}}) begin
                r_run <= w_run + 1'b1;
            end else begin
                r_run <= w_run;
            end
            if (w_run >= filter_th) begin
                r_cap_f <= r_cap_s;
            end
        end
    end

    assign w_cap_f = r_cap_f;
`else
    logic w_unused_th;

    assign w_cap_f     = r_cap_s;
    assign w_unused_th = ^filter_th;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_f_d <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            r_cap_f_d <= w_cap_f;
            rise      <= w_cap_f & ~r_cap_f_d;
            fall      <= ~w_cap_f & r_cap_f_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_cap_cmp_chn.sv
// ============================================================================
// Module   : timer_cap_cmp_chn
// Purpose  : One capture/compare channel fed by a down-counting timer.
//            Optional capture glitch filter: define TIMER_CAP_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timer_cap_cmp_chn
    import timer_chn_pkg::*;
#(
    parameter int TIMER_WIDTH      = 16,
    parameter int FILTER_WIDTH     = 8,
    parameter int SIMULATION_DELAY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TIMER_WIDTH-1:0]  timer_cnt_now_v,
    input  logic                    timer_started,
    input  logic                    timer_expired,
    input  logic                    chn_mode,
    input  logic [TIMER_WIDTH-1:0]  cmp_val,
    input  logic                    cmp_pol,
    input  logic [1:0]              cap_edge_sel,
    input  logic [FILTER_WIDTH-1:0] cap_filter_th,
    input  logic                    cap_in,
    input  logic                    cap_rd,
    input  logic                    cap_ovr_clr,
    output logic                    cmp_out,
    output logic                    cmp_itr_req,
    output logic [TIMER_WIDTH-1:0]  cap_val_o,
    output logic                    cap_vld,
    output logic                    cap_itr_req,
    output logic                    cap_ovr
);

    // Out-of-range configurations elaborate an empty marker block only.
    if ((TIMER_WIDTH < 8) || (TIMER_WIDTH > 32) || (SIMULATION_DELAY < 0)) begin : g_param_out_of_range
    end

    logic [TIMER_WIDTH-1:0] r_cmp_shadow;
    logic [TIMER_WIDTH-1:0] r_cnt_d;
    logic                   r_pending;
    logic                   w_cmp_en;
    logic                   w_cmp_active;
    logic                   w_cmp_match;
    logic                   w_shadow_load;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cap_evt;
    logic                   w_ovr_set;

    cap_in_filter #(
        .FILTER_WIDTH (FILTER_WIDTH)
    ) u_cap_in_filter (
        .clk       (clk),
        .rst       (rst),
        .cap_in    (cap_in),
        .filter_th (cap_filter_th),
        .rise      (w_rise),
        .fall      (w_fall)
    );

    // ------------------------------------------------------------------
    // Compare path: shadow reloads only at period boundaries or when idle
    // ------------------------------------------------------------------
    assign w_cmp_en      = timer_started && (chn_mode == CHN_MODE_CMP);
    assign w_cmp_active  = w_cmp_en && (timer_cnt_now_v <= r_cmp_shadow);
    assign w_cmp_match   = w_cmp_en && (timer_cnt_now_v == r_cmp_shadow)
                                    && (timer_cnt_now_v != r_cnt_d);
    assign w_shadow_load = ~timer_started || timer_expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmp_shadow <= '0;
            r_cnt_d      <= '0;
            cmp_out      <= cmp_pol;
            cmp_itr_req  <= 1'b0;
        end else begin
            if (w_shadow_load) begin
                r_cmp_shadow <= cmp_val;
            end
            r_cnt_d     <= timer_cnt_now_v;
            cmp_out     <= w_cmp_active ^ cmp_pol;
            cmp_itr_req <= w_cmp_match;
        end
    end

    // ------------------------------------------------------------------
    // Capture path
    // ------------------------------------------------------------------
    assign w_cap_evt = cap_edge_hit(cap_edge_sel, w_rise, w_fall)
                       && (chn_mode == CHN_MODE_CAP) && timer_started;
    // A read in the capture cycle consumes the previous value, so no overrun.
    assign w_ovr_set = w_cap_evt && r_pending && ~cap_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_val_o   <= '0;
            cap_vld     <= 1'b0;
            cap_itr_req <= 1'b0;
            r_pending   <= 1'b0;
            cap_ovr     <= 1'b0;
        end else begin
            cap_vld     <= w_cap_evt;
            cap_itr_req <= cap_vld;
            if (w_cap_evt) begin
                cap_val_o <= timer_cnt_now_v;
                r_pending <= 1'b1;
            end else if (cap_rd) begin
                r_pending <= 1'b0;
            end
            if (w_ovr_set) begin
                cap_ovr <= 1'b1;
            end else if (cap_ovr_clr) begin
                cap_ovr <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/timer_cap_cmp_chn.md
Name: timer_cap_cmp_chn

Overview:
- One capture/compare channel, directly downstream of the basic down-counting timer.
- Consumes the timer's live count, running flag and expiry pulse.
- Compare mode: PWM output with a shadowed compare value, plus a match interrupt.
- Capture mode: latches the live count on a selected, synchronised (optionally filtered) input edge, plus a capture interrupt and overrun flag.

Parameters:
- timer_width, 16, width of count/compare/capture values (8..32).
- filter_width, 8, width of capture glitch-filter threshold.
- simulation_delay, 1, delay on registered assignments for simulation only.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- timer_cnt_now_v  in  timer_width  live timer count (counts down, reloads after 0).
- timer_started  in  1  timer running.
- timer_expired  in  1  one-cycle pulse: count is 0 and about to reload.
- chn_mode  in  1  0 = compare, 1 = capture.
- cmp_val  in  timer_width  compare value (software side).
- cmp_pol  in  1  output polarity; 1 inverts cmp_out.
- cap_edge_sel  in  2  00 none, 01 rising, 10 falling, 11 both.
- cap_filter_th  in  filter_width  input must be stable for th+1 cycles.
- cap_in  in  1  asynchronous capture pin.
- cap_rd  in  1  pulse: software has read cap_val_o.
- cap_ovr_clr  in  1  pulse: clear cap_ovr.
- cmp_out  out  1  PWM output.
- cmp_itr_req  out  1  compare-match interrupt pulse.
- cap_val_o  out  timer_width  last captured count.
- cap_vld  out  1  one-cycle pulse: cap_val_o updated.
- cap_itr_req  out  1  capture interrupt pulse, cap_vld delayed 1 clk.
- cap_ovr  out  1  sticky overrun flag.

Behaviour:
- Clock and reset:
  - Clocked on clk; synchronous active-high reset rst. Clock port is clk, reset port is rst.
  - Reset values: cmp_out = cmp_pol (inactive), all pulses 0, cap_val_o 0, cap_ovr 0, cmp_shadow 0, sync/filter/edge regs 0, pending 0.
  - rst mid-operation clears everything in the same cycle; no capture or interrupt is generated from pre-reset state.
- Compare shadow:
  - cmp_shadow <= cmp_val when ~timer_started or timer_expired. Otherwise held, giving glitch-free PWM updates at period boundaries.
- Compare output:
  - active = timer_started & (chn_mode==0) & (timer_cnt_now_v <= cmp_shadow).
  - cmp_out <= active ^ cmp_pol, registered, 1-cycle latency.
  - cmp_shadow 0: active only while count == 0.
  - cmp_shadow >= autoload: active for the whole period (100%).
- Compare match interrupt:
  - cnt_d holds the previous count.
  - cmp_itr_req <= started & mode 0 & (cnt == cmp_shadow) & (cnt != cnt_d). One pulse per entry into the match value; no repeat while the prescaler holds the count.
- Capture input path:
  - cap_in passes through a 2-flop synchroniser to cap_s, then the filter (see Optional Feature) to cap_f, then edge register cap_f_d.
  - Edge detected when cap_f != cap_f_d and the edge direction is enabled in cap_edge_sel.
- Capture action:
  - Occurs when edge & chn_mode==1 & timer_started. Same cycle: cap_val_o <= timer_cnt_now_v, cap_vld <= 1. Next cycle: cap_itr_req = 1.
  - Edges while not started, in mode 0, or with sel 00 are discarded.
- Latency (no filter): cap_vld asserts 3 clk after the first clk edge sampling the new cap_in level.
- Overrun:
  - pending sets on capture and clears on cap_rd.
  - Capture while pending (and no cap_rd that cycle): cap_val_o is still overwritten and cap_ovr is set.
  - cap_rd and capture in the same cycle: pending stays 1 and no overrun.
  - cap_ovr clears only on cap_ovr_clr. If set and clear coincide, set wins.

Optional Feature:
- Macro TIMER_CAP_FILTER_EN.
- Defined:
  - A filter counter restarts whenever cap_s != cap_s_d.
  - cap_f takes cap_s once cap_s has been stable for cap_filter_th+1 cycles; counter saturates.
  - Latency is 3 + cap_filter_th + 1 clk.
  - Pulses shorter than th+1 cycles are rejected.
- Undefined: cap_f = cap_s, cap_filter_th is ignored, latency is 3 clk, no filter counter is synthesised.

Decomposition:
- Shared package timer_chn_pkg:
  - mode constants CHN_MODE_CMP / CHN_MODE_CAP.
  - edge-select encodings CAP_EDGE_NONE / RISE / FALL / BOTH.
- One sub-module: cap_in_filter (synchroniser + optional glitch filter + edge detect), outputs rise/fall pulses.

Test Plan:
- Compare PWM: autoload 9, prescale 0, cmp_val 3, pol 0, started → cmp_out high for 4 of every 10 cycles (count 3..0), cmp_itr_req once per period at count 3.
- Shadow update: change cmp_val 3→6 mid-period → duty stays 4/10 until after timer_expired, then 7/10; cmp_val ≥ 9 → cmp_out constantly 1.
- Rising capture, no filter: mode 1, sel 01, cap_in 0→1 → cap_vld 3 clk later with cap_val_o equal to the count that cycle; cap_itr_req 1 clk after; falling edge ignored.
- Overrun: two captures without cap_rd → cap_ovr=1, cap_val_o holds the second value; cap_ovr_clr → 0; cap_rd coincident with a capture → no overrun.
- Filter (TIMER_CAP_FILTER_EN, th=4): 3-cycle pulse → no capture; 10-cycle pulse → capture 8 clk after rise, sel 11 also captures the fall.
- Reset/stop: rst asserted mid-PWM → next cycle cmp_out=cmp_pol and pulses 0; edge with timer_started=0 → no cap_vld.
